// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Define MEM_PORT_ARB_RR_EN to use round-robin arbitration instead of fixed data-first priority.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

    state_t            state_q, state_d;
    logic              owner_fetch_q, owner_fetch_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              grant_data;

`ifdef MEM_PORT_ARB_RR_EN
    // Set when the last grant went to data, so fetch wins the next tie.
    logic              last_data_q, last_data_d;
    assign grant_data = d_req && (!if_req || !last_data_q);
`else
    assign grant_data = d_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            owner_fetch_q <= 1'b0;
            cnt_q         <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            if_rdata_q    <= '0;
            d_rdata_q     <= '0;
`ifdef MEM_PORT_ARB_RR_EN
            last_data_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            owner_fetch_q <= owner_fetch_d;
            cnt_q         <= cnt_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            if_rdata_q    <= if_rdata_d;
            d_rdata_q     <= d_rdata_d;
`ifdef MEM_PORT_ARB_RR_EN
            last_data_q   <= last_data_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_fetch_d = owner_fetch_q;
        cnt_d         = cnt_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;
`ifdef MEM_PORT_ARB_RR_EN
        last_data_d   = last_data_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_data) begin
                    mem_addr_d    = d_addr;
                    mem_wdata_d   = d_wdata;
                    mem_we_d      = d_we;
                    owner_fetch_d = 1'b0;
                    state_d       = S_ISSUE;
`ifdef MEM_PORT_ARB_RR_EN
                    last_data_d   = 1'b1;
`endif
                end else if (if_req) begin
                    mem_addr_d    = if_addr;
                    mem_we_d      = 1'b0;
                    owner_fetch_d = 1'b1;
                    state_d       = S_ISSUE;
`ifdef MEM_PORT_ARB_RR_EN
                    last_data_d   = 1'b0;
`endif
                end
            end
            S_ISSUE: begin
                cnt_d   = LAT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // Read data is valid in the cycle the counter sits at 1.
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    if (!mem_we_q) begin
                        if (owner_fetch_q) if_rdata_d = mem_rdata;
                        else               d_rdata_d  = mem_rdata;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_en    = (state_q == S_ISSUE);
        busy      = (state_q != S_IDLE);
        if_ack    = (state_q == S_RESP) &&  owner_fetch_q;
        d_ack     = (state_q == S_RESP) && !owner_fetch_q;
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        if_rdata  = if_rdata_q;
        d_rdata   = d_rdata_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random requesters, a latency-accurate memory, and a cycle-level reference model.
module tb_mem_port_arbiter;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        if_ack, d_ack, mem_en, mem_we, busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct { bit wr; logic [31:0] data; } exp_t;
    typedef struct { int vc; logic [31:0] d; } rd_t;

    exp_t        if_q[$];
    exp_t        d_q[$];
    rd_t         rd_q[$];
    logic [31:0] mem_blk [128];
    logic [31:0] ref_mem [128];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endfunction

    // Memory block: writes land on the strobe, read data appears exactly LAT cycles later, noise otherwise.
    int mcyc = 0;
    initial begin
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mcyc++;
            if (rst_n && mem_en) begin
                if (mem_we) mem_blk[mem_addr[8:2]] = mem_wdata;
                else        rd_q.push_back('{mcyc + LAT, mem_blk[mem_addr[8:2]]});
            end
            if (rd_q.size() > 0 && rd_q[0].vc == mcyc) begin
                mem_rdata = rd_q[0].d;
                void'(rd_q.pop_front());
            end else begin
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor: predicts strobe, busy and ack timing from request history and pops the scoreboards on acks.
    int          cyc = 0;
    int          busy_until = -100;
    int          ack_cyc = -100;
    bit          ack_fetch = 1'b0;
    bit          last_data = 1'b0;
    logic [31:0] exp_ifr = '0;
    logic [31:0] exp_dr = '0;

    initial begin
        forever begin
            bit   exp_en, win_d;
            exp_t e;
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                busy_until = -100;
                ack_cyc    = -100;
                last_data  = 1'b0;
                exp_ifr    = '0;
                exp_dr     = '0;
                check1("rst_busy", busy, 1'b0);
                check1("rst_mem_en", mem_en, 1'b0);
                check1("rst_mem_we", mem_we, 1'b0);
                check1("rst_if_ack", if_ack, 1'b0);
                check1("rst_d_ack", d_ack, 1'b0);
                check("rst_mem_addr", mem_addr, 32'h0);
                check("rst_mem_wdata", mem_wdata, 32'h0);
                check("rst_if_rdata", if_rdata, 32'h0);
                check("rst_d_rdata", d_rdata, 32'h0);
            end else begin
                exp_en = (cyc - 1 > busy_until) && (if_req || d_req);
                check1("mem_en", mem_en, exp_en);
                if (exp_en) begin
`ifdef MEM_PORT_ARB_RR_EN
                    win_d = d_req && (!if_req || !last_data);
`else
                    win_d = d_req;
`endif
                    last_data = win_d;
                    if (win_d) begin
                        check("issue_d_addr", mem_addr, d_addr);
                        check1("issue_d_we", mem_we, d_we);
                        if (d_we) check("issue_d_wdata", mem_wdata, d_wdata);
                    end else begin
                        check("issue_if_addr", mem_addr, if_addr);
                        check1("issue_if_we", mem_we, 1'b0);
                    end
                    busy_until = cyc + LAT + 1;
                    ack_cyc    = busy_until;
                    ack_fetch  = !win_d;
                end
                check1("busy", busy, cyc <= busy_until);
                check1("if_ack", if_ack, (cyc == ack_cyc) && ack_fetch);
                check1("d_ack", d_ack, (cyc == ack_cyc) && !ack_fetch);
                if (if_ack) begin
                    if (if_q.size() == 0) begin
                        check1("if_ack_unrequested", if_ack, 1'b0);
                    end else begin
                        e = if_q.pop_front();
                        exp_ifr = e.data;
                        check("if_rdata", if_rdata, exp_ifr);
                    end
                    check("d_rdata_hold", d_rdata, exp_dr);
                end
                if (d_ack) begin
                    if (d_q.size() == 0) begin
                        check1("d_ack_unrequested", d_ack, 1'b0);
                    end else begin
                        e = d_q.pop_front();
                        if (!e.wr) exp_dr = e.data;
                        check(e.wr ? "d_rdata_after_write" : "d_rdata", d_rdata, exp_dr);
                    end
                    check("if_rdata_hold", if_rdata, exp_ifr);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
        if (if_ack) if_req = 1'b0;
        if (d_ack)  d_req  = 1'b0;
    endtask

    task automatic issue_f(input logic [31:0] a);
        if_addr = a;
        if_req  = 1'b1;
        if_q.push_back('{1'b0, ref_mem[a[8:2]]});
    endtask

    task automatic issue_d(input bit we, input logic [31:0] a, input logic [31:0] w);
        d_we    = we;
        d_addr  = a;
        d_wdata = w;
        d_req   = 1'b1;
        if (we) begin
            ref_mem[a[8:2]] = w;
            d_q.push_back('{1'b1, 32'h0});
        end else begin
            d_q.push_back('{1'b0, ref_mem[a[8:2]]});
        end
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        while ((if_req || d_req) && n < budget) begin
            step();
            n++;
        end
        check1("drain_timeout", if_req || d_req, 1'b0);
    endtask

    initial begin
        logic [31:0] a;
        int          n;
        for (int i = 0; i < 128; i++) begin
            ref_mem[i] = $urandom;
            mem_blk[i] = ref_mem[i];
        end
        ref_mem[1] = 32'h8C01_0000;  mem_blk[1] = 32'h8C01_0000;
        ref_mem[0] = 32'h0000_0123;  mem_blk[0] = 32'h0000_0123;

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        step(); issue_f(32'h4);                                      wait_quiet(50);
        step(); issue_d(1'b1, 32'h10, 32'hDEAD_BEEF);                wait_quiet(50);
        step(); issue_f(32'h8);  issue_d(1'b0, 32'h20, 32'h0);       wait_quiet(50);
        step(); issue_f(32'hC);  issue_d(1'b0, 32'h24, 32'h0);       wait_quiet(50);
        step(); issue_d(1'b0, 32'h0, 32'h0);                         wait_quiet(50);
        step(); issue_f(32'h10);                                     wait_quiet(50);

        for (int i = 0; i < 3000; i++) begin
            step();
            if (!if_req && $urandom_range(0, 2) == 0) begin
                a = 32'($urandom_range(0, 63)) << 2;
                issue_f(a);
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                a = 32'h100 + (32'($urandom_range(0, 63)) << 2);
                issue_d(bit'($urandom_range(0, 1)), a, $urandom);
            end
        end
        wait_quiet(100);

        // Abort a fetch in the middle of its wait: it must never be acknowledged.
        step(); issue_f(32'h4);
        n = 0;
        while (!mem_en && n < 10) begin
            step();
            n++;
        end
        check1("abort_issue_timeout", mem_en, 1'b1);
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        if_req = 1'b0;
        d_req  = 1'b0;
        if_q.delete();
        d_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) step();
        step(); issue_d(1'b0, 32'h104, 32'h0); wait_quiet(50);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
